// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit owning the HI/LO registers.
// It runs MULT, MULTU, DIV and DIVU in 34 busy cycles and handles MTHI/MTLO writes.
// Ports:
//   clk, reset       rising-edge clock; synchronous, active-high reset
//   start, op        launch an operation (sampled in IDLE only);
//                    op = 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A, B             operands; A is also the MTHI/MTLO data source
//   mthi, mtlo       write A into HI / LO (honoured in IDLE only)
//   busy             an operation is in flight
//   done             one-cycle pulse when HI/LO hold a new result
//   div_by_zero      the last DIV/DIVU had B == 0
//   HI, LO           result registers, read by the write-back mux
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic                 r_load;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_div;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_dz;
    logic                 r_done;
    logic                 r_dbz;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic [2*WIDTH-1:0]   r_acc;

    logic                 w_signed;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rs;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_n;
    logic [2*WIDTH-1:0]   w_div_next;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_q_raw;
    logic [WIDTH-1:0]     w_r_raw;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;

    // Unsigned ops use the raw operands; signed ops work on magnitudes.
    assign w_signed = ~op[0];
    assign w_a_mag  = (w_signed && A[WIDTH-1]) ? (-A) : A;
    assign w_b_mag  = (w_signed && B[WIDTH-1]) ? (-B) : B;

    // Multiply: acc = {partial, multiplier}; add multiplicand, shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; restoring step.
    // The shifted remainder needs one extra bit before the compare.
    assign w_rs       = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge       = (w_rs >= {1'b0, r_b});
    assign w_diff     = w_rs - {1'b0, r_b};
    assign w_rem_n    = w_ge ? w_diff[WIDTH-1:0] : w_rs[WIDTH-1:0];
    assign w_div_next = {w_rem_n, r_acc[WIDTH-2:0], w_ge};

    // Sign fix-up. With B == 0 the remainder ends up as |A|, so
    // re-applying A's sign returns the raw dividend.
    assign w_prod  = r_neg_q ? (-r_acc) : r_acc;
    assign w_q_raw = r_acc[WIDTH-1:0];
    assign w_r_raw = r_acc[2*WIDTH-1:WIDTH];
    assign w_quo   = r_neg_q ? (-w_q_raw) : w_q_raw;
    assign w_rem   = r_neg_r ? (-w_r_raw) : w_r_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_RUN;
            S_RUN: begin
                if (!r_load && (r_cnt == {CNT_W{1'b1}})) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        done        = r_done;
        div_by_zero = r_dbz;
        HI          = r_hi;
        LO          = r_lo;
    end

    // The first RUN edge loads the working register from the latched
    // operands; the next 2^CNT_W edges are the iterations proper.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load   <= 1'b0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_acc    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_is_div <= op[1];
                        r_a      <= w_a_mag;
                        r_b      <= w_b_mag;
                        r_neg_q  <= w_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_r  <= w_signed & A[WIDTH-1];
                        r_dz     <= op[1] & (B == '0);
                        r_cnt    <= '0;
                        r_load   <= 1'b1;
                        r_dbz    <= 1'b0;
                    end else begin
                        if (mthi) r_hi <= A;
                        if (mtlo) r_lo <= A;
                    end
                end
                S_RUN: begin
                    if (r_load) begin
                        r_load <= 1'b0;
                        r_acc  <= {{WIDTH{1'b0}}, (r_is_div ? r_a : r_b)};
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        r_lo  <= r_dz ? {WIDTH{1'b1}} : w_quo;
                        r_hi  <= w_rem;
                        r_dbz <= r_dz;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vector table plus hand-written sequences
// for the mult_div_unit latency, ignore, move and reset corner cases.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_pass = 0;
    int n_total = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .HI          (HI),
        .LO          (LO)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v,
                           input logic [31:0] ph, input logic [31:0] pl);
        int n;
        op = v.op;
        A = v.a;
        B = v.b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = 32'h5A5A_5A5A;
        B = 32'h0000_0003;
        chk($sformatf("v%0d dbz_clear_at_start", idx), div_by_zero, 0);
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 17) begin
                chk($sformatf("v%0d hi_hold", idx), HI, ph);
                chk($sformatf("v%0d lo_hold", idx), LO, pl);
            end
            tick();
        end
        chk($sformatf("v%0d busy_cycles", idx), n, 34);
        chk($sformatf("v%0d done", idx), done, 1);
        chk($sformatf("v%0d hi", idx), HI, v.hi);
        chk($sformatf("v%0d lo", idx), LO, v.lo);
        chk($sformatf("v%0d dbz", idx), div_by_zero, v.dbz);
        tick();
        chk($sformatf("v%0d done_pulse", idx), done, 0);
    endtask

    initial begin
        int n;
        int dcount;
        logic [31:0] ph;
        logic [31:0] pl;

        vecs[0] = '{2'b00, 32'd7,         32'hFFFF_FFFD,
                    32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'h0,         32'h1,         1'b0};
        vecs[3] = '{2'b10, 32'hFFFF_FFF9, 32'd2,
                    32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[4] = '{2'b11, 32'd100,       32'd7,
                    32'd2,         32'd14,        1'b0};
        vecs[5] = '{2'b11, 32'd100,       32'd0,
                    32'd100,       32'hFFFF_FFFF, 1'b1};
        vecs[6] = '{2'b00, 32'd6,         32'd9,
                    32'h0,         32'd54,        1'b0};
        vecs[7] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
                    32'h0,         32'h8000_0000, 1'b0};
        vecs[8] = '{2'b10, 32'hFFFF_FFF9, 32'd0,
                    32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[9] = '{2'b10, 32'd7,         32'hFFFF_FFFE,
                    32'd1,         32'hFFFF_FFFD, 1'b0};

        reset = 1'b1;
        start = 1'b0;
        op = 2'b00;
        A = '0;
        B = '0;
        mthi = 1'b0;
        mtlo = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset dbz", div_by_zero, 0);
        chk("reset hi", HI, 0);
        chk("reset lo", LO, 0);

        ph = '0;
        pl = '0;
        for (int i = 0; i < 10; i++) begin
            run_vec(i, vecs[i], ph, pl);
            ph = vecs[i].hi;
            pl = vecs[i].lo;
        end

        // start/mthi/A change while busy are ignored
        op = 2'b00;
        A = 32'd3;
        B = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        start = 1'b1;
        mthi = 1'b1;
        A = 32'h0000_DEAD;
        B = 32'd11;
        tick();
        start = 1'b0;
        mthi = 1'b0;
        wait_idle(n);
        chk("busy_ign cycles", n + 5, 34);
        chk("busy_ign done", done, 1);
        chk("busy_ign hi", HI, 0);
        chk("busy_ign lo", LO, 32'd15);

        // back-to-back start in the done cycle
        op = 2'b01;
        A = 32'd2;
        B = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b busy", busy, 1);
        wait_idle(n);
        chk("b2b cycles", n, 34);
        chk("b2b lo", LO, 32'd6);
        tick();

        // moves in IDLE
        A = 32'h1234_5678;
        mthi = 1'b1;
        tick();
        mthi = 1'b0;
        chk("mthi hi", HI, 32'h1234_5678);
        chk("mthi lo", LO, 32'd6);
        chk("mthi done", done, 0);
        A = 32'hCAFE_BABE;
        mthi = 1'b1;
        mtlo = 1'b1;
        tick();
        mthi = 1'b0;
        mtlo = 1'b0;
        chk("both hi", HI, 32'hCAFE_BABE);
        chk("both lo", LO, 32'hCAFE_BABE);
        chk("both done", done, 0);

        // start beats a simultaneous mthi
        op = 2'b01;
        A = 32'd2;
        B = 32'd2;
        start = 1'b1;
        mthi = 1'b1;
        tick();
        start = 1'b0;
        mthi = 1'b0;
        chk("start_wins hi", HI, 32'hCAFE_BABE);
        wait_idle(n);
        chk("start_wins lo", LO, 32'd4);
        chk("start_wins hi2", HI, 32'd0);
        tick();

        // reset mid-operation discards the result
        op = 2'b11;
        A = 32'd100;
        B = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst busy", busy, 0);
        chk("midrst hi", HI, 0);
        chk("midrst lo", LO, 0);
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) dcount++;
            tick();
        end
        chk("midrst no_done", dcount, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
